fpga_cfg_loader: RTL and testbench

Serial configuration loader for the fpga fabric. It hunts for a sync word and deserializes a CFG_WIDTH-bit bitstream, MSB first. It checks an even-parity bit, then drives the parallel programming word into the fabric's prog_in and releases the fabric reset. It also supports serial readback of the loaded word, which is the reverse of the load path.

---
 rtl/fpga_cfg_loader.sv | 118 +++++++++++
 tb/tb_fpga_cfg_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fpga_cfg_loader.sv
// fpga_cfg_loader: sync-word hunting serial loader with even parity check,
// parallel programming word and fabric reset release, plus serial readback.
module fpga_cfg_loader #(
  parameter int          CFG_WIDTH = 116,
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int          CNT_W     = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cfg_valid,
  input  logic                 cfg_bit,
  output logic                 cfg_ready,
  input  logic                 cfg_restart,
  input  logic                 rb_req,
  output logic                 rb_valid,
  output logic                 rb_bit,
  output logic [CFG_WIDTH-1:0] prog_out,
  output logic                 fabric_reset,
  output logic                 cfg_done,
  output logic                 cfg_error
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PARITY, S_DONE, S_READBACK, S_ERROR} state_t;
  state_t               state_q;
  logic [7:0]           sync_q;
  logic [7:0]           sync_d;
  logic [CFG_WIDTH-1:0] shadow_q;
  logic [CFG_WIDTH-1:0] shadow_d;
  logic [CFG_WIDTH-1:0] prog_q;
  logic [CFG_WIDTH-1:0] rb_sh_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     rb_cnt_q;
  logic                 rb_valid_q;
  logic                 rb_bit_q;
  logic                 fab_rst_q;
  logic                 done_q;
  logic                 err_q;
  logic                 acc;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CFG_WIDTH - 1);
  // ready is forced low while reset is held, not only after the state settles
  assign cfg_ready    = reset && (state_q == S_IDLE || state_q == S_LOAD || state_q == S_PARITY);
  assign acc          = cfg_valid && cfg_ready;
  assign sync_d       = {sync_q[6:0], cfg_bit};
  assign shadow_d     = {shadow_q[CFG_WIDTH-2:0], cfg_bit};
  assign prog_out     = prog_q;
  assign rb_valid     = rb_valid_q;
  assign rb_bit       = rb_bit_q;
  assign fabric_reset = fab_rst_q;
  assign cfg_done     = done_q;
  assign cfg_error    = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      sync_q     <= '0;
      shadow_q   <= '0;
      prog_q     <= '0;
      rb_sh_q    <= '0;
      cnt_q      <= '0;
      rb_cnt_q   <= '0;
      rb_valid_q <= 1'b0;
      rb_bit_q   <= 1'b0;
      fab_rst_q  <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (acc) begin
          sync_q <= sync_d;
          if (sync_d == SYNC_WORD) begin
            state_q <= S_LOAD;
            cnt_q   <= '0;
          end
        end
        S_LOAD: if (acc) begin
          shadow_q <= shadow_d;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= S_PARITY;
        end
        S_PARITY: if (acc) begin
          if (^{shadow_q, cfg_bit} == 1'b0) begin
            state_q   <= S_DONE;
            prog_q    <= shadow_q;
            done_q    <= 1'b1;
            fab_rst_q <= 1'b0;
          end else begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end
        end
        S_DONE, S_ERROR: if (cfg_restart) begin
          state_q   <= S_IDLE;
          prog_q    <= '0;
          fab_rst_q <= 1'b1;
          done_q    <= 1'b0;
          err_q     <= 1'b0;
          sync_q    <= '0;
          cnt_q     <= '0;
        end else if (rb_req && state_q == S_DONE) begin
          // first bit is presented straight away; the shadow copy feeds the rest
          state_q    <= S_READBACK;
          rb_sh_q    <= prog_q;
          rb_bit_q   <= prog_q[CFG_WIDTH-1];
          rb_valid_q <= 1'b1;
          rb_cnt_q   <= '0;
        end
        S_READBACK: if (rb_cnt_q == LAST) begin
          state_q    <= S_DONE;
          rb_valid_q <= 1'b0;
          rb_bit_q   <= 1'b0;
        end else begin
          rb_bit_q <= rb_sh_q[CFG_WIDTH-2];
          rb_sh_q  <= rb_sh_q << 1;
          rb_cnt_q <= rb_cnt_q + 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb_fpga_cfg_loader: scoreboard bench for the serial configuration loader.
module tb_fpga_cfg_loader;
  localparam int         W    = 116;
  localparam logic [7:0] SYNC = 8'hA5;
  logic         clk = 1'b0;
  logic         reset;
  logic         cfg_valid;
  logic         cfg_bit;
  logic         cfg_ready;
  logic         cfg_restart;
  logic         rb_req;
  logic         rb_valid;
  logic         rb_bit;
  logic [W-1:0] prog_out;
  logic         fabric_reset;
  logic         cfg_done;
  logic         cfg_error;
  int           checks = 0;
  int           errors = 0;
  logic [W+1:0] res_q[$];
  logic         rb_q[$];
  logic [W-1:0] model_prog;
  fpga_cfg_loader dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
    .cfg_ready(cfg_ready), .cfg_restart(cfg_restart), .rb_req(rb_req),
    .rb_valid(rb_valid), .rb_bit(rb_bit), .prog_out(prog_out),
    .fabric_reset(fabric_reset), .cfg_done(cfg_done), .cfg_error(cfg_error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic send_bit(input logic b, input bit rnd);
    if (rnd && $urandom_range(1, 0) == 1) begin
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b1;
    cfg_bit   = b;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask
  task automatic send_frame(input logic [W-1:0] p, input logic par, input bit rnd);
    logic ok;
    ok = (^{p, par}) == 1'b0;
    if (ok) model_prog = p;
    res_q.push_back({ok, !ok, model_prog});
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], rnd);
    for (int i = W - 1; i >= 0; i--) send_bit(p[i], rnd);
    send_bit(par, rnd);
  endtask
  task automatic wait_result;
    logic [W+1:0] e;
    int           n;
    n = 0;
    @(negedge clk);
    while (!(cfg_done || cfg_error) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50 || res_q.size() == 0) begin
      chk("res_timeout", 128'(n), 128'(0));
    end else begin
      e = res_q.pop_front();
      chk("res_done", 128'(cfg_done), 128'(e[W+1]));
      chk("res_error", 128'(cfg_error), 128'(e[W]));
      chk("res_prog", 128'(prog_out), 128'(e[W-1:0]));
      chk("res_fabrst", 128'(fabric_reset), 128'(!e[W+1]));
      chk("res_ready", 128'(cfg_ready), 128'(0));
    end
  endtask
  task automatic restart;
    cfg_restart = 1'b1;
    @(posedge clk);
    #1;
    cfg_restart = 1'b0;
    model_prog  = '0;
    @(negedge clk);
    chk("rs_done", 128'(cfg_done), 128'(0));
    chk("rs_error", 128'(cfg_error), 128'(0));
    chk("rs_prog", 128'(prog_out), 128'(0));
    chk("rs_fabrst", 128'(fabric_reset), 128'(1));
    chk("rs_ready", 128'(cfg_ready), 128'(1));
  endtask
  task automatic readback(input int abort_at);
    int n;
    int idle;
    n    = 0;
    idle = 0;
    for (int i = W - 1; i >= 0; i--) rb_q.push_back(model_prog[i]);
    rb_req = 1'b1;
    @(posedge clk);
    #1;
    rb_req = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (rb_valid) begin
        if (rb_q.size() == 0) chk("rb_extra", 128'(n), 128'(W));
        else chk("rb_bit", 128'(rb_bit), 128'(rb_q.pop_front()));
        chk("rb_prog", 128'(prog_out), 128'(model_prog));
        n++;
        cfg_restart = (n == 10);
        if (n == abort_at) begin
          reset = 1'b0;
          #1;
          chk("ab_rbvalid", 128'(rb_valid), 128'(0));
          chk("ab_prog", 128'(prog_out), 128'(0));
          chk("ab_fabrst", 128'(fabric_reset), 128'(1));
          chk("ab_done", 128'(cfg_done), 128'(0));
          rb_q.delete();
          model_prog = '0;
          break;
        end
      end else if (n > 0) begin
        break;
      end else begin
        idle++;
      end
    end
    cfg_restart = 1'b0;
    chk("rb_lat", 128'(idle), 128'(0));
    if (abort_at == 0) begin
      chk("rb_len", 128'(n), 128'(W));
      chk("rb_left", 128'(rb_q.size()), 128'(0));
      chk("rb_done_kept", 128'(cfg_done), 128'(1));
      chk("rb_ready", 128'(cfg_ready), 128'(0));
    end
  endtask
  initial begin
    logic [W-1:0] big;
    logic [W-1:0] alt;
    reset       = 1'b0;
    cfg_valid   = 1'b0;
    cfg_bit     = 1'b0;
    cfg_restart = 1'b0;
    rb_req      = 1'b0;
    model_prog  = '0;
    repeat (10) @(posedge clk);
    chk("rst_ready", 128'(cfg_ready), 128'(0));
    chk("rst_fabrst", 128'(fabric_reset), 128'(1));
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rel_prog", 128'(prog_out), 128'(0));
    chk("rel_fabrst", 128'(fabric_reset), 128'(1));
    chk("rel_ready", 128'(cfg_ready), 128'(1));
    chk("rel_done", 128'(cfg_done), 128'(0));
    chk("rel_rbvalid", 128'(rb_valid), 128'(0));
    // rb_req in IDLE has no effect
    rb_req = 1'b1;
    @(posedge clk);
    #1 rb_req = 1'b0;
    @(negedge clk);
    chk("idle_rb", 128'(rb_valid), 128'(0));
    send_frame(W'(1), 1'b1, 1'b0);
    wait_result();
    restart();
    repeat (4) send_bit(1'b1, 1'b0);
    send_frame(W'(3), ^W'(3), 1'b0);
    wait_result();
    restart();
    send_frame(W'(1), 1'b0, 1'b0);
    wait_result();
    restart();
    send_frame(W'(5), ^W'(5), 1'b0);
    wait_result();
    restart();
    big = '0;
    big[W-1] = 1'b1;
    big[0]   = 1'b1;
    send_frame(big, ^big, 1'b1);
    wait_result();
    readback(0);
    restart();
    // abort a load part way through the payload
    for (int i = 7; i >= 0; i--) send_bit(SYNC[i], 1'b0);
    for (int i = 0; i < 60; i++) send_bit(i[0], 1'b0);
    reset = 1'b0;
    #2;
    chk("ml_ready", 128'(cfg_ready), 128'(0));
    chk("ml_fabrst", 128'(fabric_reset), 128'(1));
    chk("ml_done", 128'(cfg_done), 128'(0));
    chk("ml_prog", 128'(prog_out), 128'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    alt = {29{4'hA}};
    send_frame(alt, ^alt, 1'b0);
    wait_result();
    readback(30);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("post_ready", 128'(cfg_ready), 128'(1));
    send_frame(~alt, ^(~alt), 1'b1);
    wait_result();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
